seg7_rx_monitor: RTL and testbench
==================================

SEG7_RX_MONITOR -- requirements
Module: seg7_rx_monitor

Interface
REQ-001 SHALL have parameter STALL_MAX, default 2, meaning the maximum number of consecutive clk cycles a valid decoded value may stay unchanged.
REQ-002 SHALL have port clk, input, 1 bit, the single clock; all logic is on the rising edge.
REQ-003 SHALL have port rst, input, 1 bit, an asynchronous active-low reset.
REQ-004 SHALL have port seg0, input, 8 bits, the ones digit pattern: bit0=a .. bit6=g, bit7=dp, active-high.
REQ-005 SHALL have port seg1, input, 8 bits, the tens digit pattern, same encoding.
REQ-006 SHALL have port seg2, input, 8 bits, the hundreds digit pattern, same encoding.
REQ-007 SHALL have port value, output, 10 bits, the last valid decoded binary value, 0..999.
REQ-008 SHALL have port value_vld, output, 1 bit, high while state is TRACK.
REQ-009 SHALL have port upd, output, 1 bit, a one-cycle pulse when value changes.
REQ-010 SHALL have port err_code, output, 1 bit, a one-cycle pulse on an undecodable pattern.
REQ-011 SHALL have port err_seq, output, 1 bit, a one-cycle pulse on a non-incrementing change.
REQ-012 SHALL have port err_stall, output, 1 bit, a one-cycle pulse on a stall timeout.
REQ-013 SHALL have port err_cnt, output, 8 bits, a saturating total error count.

Function
REQ-014 SHALL register seg0..seg2 in stage 1, then decode and evaluate in stage 2; outputs SHALL reflect the inputs 2 cycles after sampling.
REQ-015 SHALL ignore bit7 (dp) in all decoding.
REQ-016 SHALL decode these digit patterns only: 0=0x3F, 1=0x06, 2=0x5B, 3=0x4F, 4=0x66, 5=0x6D, 6=0x7D, 7=0x07, 8=0x7F, 9=0x6F.
REQ-017 SHALL decode blank 0x00 as 0 on seg2 always, and on seg1 only when seg2 is also blank (leading-zero suppression); blank seg0 SHALL be a code error.
REQ-018 SHALL treat any other pattern as a code error.
REQ-019 SHALL compute the candidate value as d2*100 + d1*10 + d0, 10 bits, with no overflow possible.
REQ-020 SHALL implement FSM state SYNC: on a valid code, load value, pulse upd, clear the stall counter, and go to TRACK.
REQ-021 SHALL, in TRACK with an unchanged candidate, increment the stall counter; when it exceeds STALL_MAX, pulse err_stall, clear the counter, and stay in TRACK.
REQ-022 SHALL, in TRACK with candidate == value+1 (or 999 -> 0 wrap), load value, pulse upd, and clear the stall counter.
REQ-023 SHALL, in TRACK with any other changed candidate, pulse err_seq, load value, pulse upd, clear the stall counter, and stay in TRACK (resync).
REQ-024 SHALL, on a code error in any state, pulse err_code, go to SYNC, and hold value; err_code SHALL take priority, and err_seq/err_stall SHALL NOT fire in the same cycle.
REQ-025 SHALL increment err_cnt by 1 on any cycle with any err pulse, saturating at 255.
REQ-026 SHALL keep value_vld low in SYNC.

Reset
REQ-027 SHALL, while rst=0, asynchronously clear all outputs, the stage-1 registers, and the stall counter to 0, and set state to SYNC.
REQ-028 SHALL, on rst release, resume sampling on the next clk edge; the first valid value SHALL give upd with no err_seq.
REQ-029 SHALL, on reset asserted mid-stream, discard the pipeline contents and emit no pulse.

Structure
REQ-030 SHALL place the ten digit-pattern constants, the blank constant, and the FSM state encoding in shared package seg7_pkg.
REQ-031 SHALL use one combinational sub-module, seg7_digit_dec (8-bit pattern in, 4-bit digit plus valid/blank flags out), instantiated three times.

Verification
REQ-032 Bench SHALL drive a counting stream 000..012, one step per clk -> value tracks with 2-cycle latency, upd every cycle, err_cnt=0.
REQ-033 Bench SHALL drive 998, 999, 000, 001 -> wrap accepted, no err_seq.
REQ-034 Bench SHALL drive 041 then 045 -> one err_seq pulse, value=45, err_cnt=1.
REQ-035 Bench SHALL drive seg0=0x49 -> err_code pulse, value_vld low, value held; the next valid code resyncs with no err_seq.
REQ-036 Bench SHALL hold 007 for 5 cycles with STALL_MAX=2 -> err_stall pulses at the 3rd unchanged cycle and periodically after, and err_cnt counts each pulse.
REQ-037 Bench SHALL assert rst=0 mid-count for 20 cycles -> all outputs are 0 immediately and stay SYNC; after release the first value gives upd with no error; dp-set and leading-blank patterns decode correctly.

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared constants for the seven-segment receive monitor: segment patterns
// (bit0=a .. bit6=g, dp excluded), value limits and the tracker state encoding.
package seg7_pkg;

    localparam logic [6:0] SEG_DIGIT_0 = 7'h3F;
    localparam logic [6:0] SEG_DIGIT_1 = 7'h06;
    localparam logic [6:0] SEG_DIGIT_2 = 7'h5B;
    localparam logic [6:0] SEG_DIGIT_3 = 7'h4F;
    localparam logic [6:0] SEG_DIGIT_4 = 7'h66;
    localparam logic [6:0] SEG_DIGIT_5 = 7'h6D;
    localparam logic [6:0] SEG_DIGIT_6 = 7'h7D;
    localparam logic [6:0] SEG_DIGIT_7 = 7'h07;
    localparam logic [6:0] SEG_DIGIT_8 = 7'h7F;
    localparam logic [6:0] SEG_DIGIT_9 = 7'h6F;
    localparam logic [6:0] SEG_BLANK   = 7'h00;

    localparam logic [9:0] VALUE_MAX   = 10'd999;
    localparam logic [7:0] ERR_CNT_MAX = 8'd255;

    typedef enum logic {
        SYNC  = 1'b0,
        TRACK = 1'b1
    } state_t;

endpackage

// File: rtl/seg7_digit_dec.sv
// Combinational decoder for one seven-segment digit; the decimal point is
// ignored, an all-dark pattern is flagged as blank rather than as a digit.
module seg7_digit_dec
    import seg7_pkg::*;
(
    input  logic [7:0] pattern,
    output logic [3:0] digit,
    output logic       valid,
    output logic       blank
);

    logic unused_dp;
    assign unused_dp = pattern[7];

    always_comb begin
        digit = 4'd0;
        valid = 1'b1;
        blank = 1'b0;
        case (pattern[6:0])
            SEG_DIGIT_0: digit = 4'd0;
            SEG_DIGIT_1: digit = 4'd1;
            SEG_DIGIT_2: digit = 4'd2;
            SEG_DIGIT_3: digit = 4'd3;
            SEG_DIGIT_4: digit = 4'd4;
            SEG_DIGIT_5: digit = 4'd5;
            SEG_DIGIT_6: digit = 4'd6;
            SEG_DIGIT_7: digit = 4'd7;
            SEG_DIGIT_8: digit = 4'd8;
            SEG_DIGIT_9: digit = 4'd9;
            SEG_BLANK: begin
                valid = 1'b0;
                blank = 1'b1;
            end
            default: valid = 1'b0;
        endcase
    end

endmodule

// File: rtl/seg7_rx_monitor.sv
// Watches a three-digit seven-segment display, recovers its binary value and
// flags undecodable patterns, non-incrementing jumps and stalled counts.
module seg7_rx_monitor
    import seg7_pkg::*;
#(
    parameter int unsigned STALL_MAX = 2
)
(
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] seg0,
    input  logic [7:0] seg1,
    input  logic [7:0] seg2,
    output logic [9:0] value,
    output logic       value_vld,
    output logic       upd,
    output logic       err_code,
    output logic       err_seq,
    output logic       err_stall,
    output logic [7:0] err_cnt
);

    localparam int unsigned       CNT_W       = $clog2(STALL_MAX + 2);
    localparam logic [CNT_W-1:0]  STALL_LIMIT = CNT_W'(STALL_MAX);

    logic [7:0]       seg0_q;
    logic [7:0]       seg1_q;
    logic [7:0]       seg2_q;
    logic             s1_vld;

    logic [3:0]       d0;
    logic [3:0]       d1;
    logic [3:0]       d2;
    logic             d0_valid;
    logic             d1_valid;
    logic             d2_valid;
    logic             d0_blank;
    logic             d1_blank;
    logic             d2_blank;

    logic             code_ok;
    logic [9:0]       candidate;
    logic [9:0]       successor;

    state_t           state;
    state_t           state_nx;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] stall_cnt_nx;
    logic [CNT_W-1:0] stall_inc;
    logic [9:0]       value_nx;
    logic             upd_nx;
    logic             err_code_nx;
    logic             err_seq_nx;
    logic             err_stall_nx;
    logic [7:0]       err_cnt_nx;

    // s1_vld keeps the reset-cleared stage-1 contents from being judged as a code error.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            seg0_q <= 8'd0;
            seg1_q <= 8'd0;
            seg2_q <= 8'd0;
            s1_vld <= 1'b0;
        end else begin
            seg0_q <= seg0;
            seg1_q <= seg1;
            seg2_q <= seg2;
            s1_vld <= 1'b1;
        end
    end

    seg7_digit_dec u_dec0 (.pattern(seg0_q), .digit(d0), .valid(d0_valid), .blank(d0_blank));
    seg7_digit_dec u_dec1 (.pattern(seg1_q), .digit(d1), .valid(d1_valid), .blank(d1_blank));
    seg7_digit_dec u_dec2 (.pattern(seg2_q), .digit(d2), .valid(d2_valid), .blank(d2_blank));

    // Leading-zero suppression: tens may be dark only when hundreds is dark too.
    assign code_ok   = d0_valid
                     && (d1_valid || (d1_blank && d2_blank))
                     && (d2_valid || d2_blank);
    assign candidate = 10'(d2) * 10'd100 + 10'(d1) * 10'd10 + 10'(d0);
    assign successor = (value == VALUE_MAX) ? 10'd0 : value + 10'd1;
    assign stall_inc = stall_cnt + 1'b1;
    assign value_vld = (state == TRACK);

    always_comb begin
        state_nx     = state;
        value_nx     = value;
        stall_cnt_nx = stall_cnt;
        upd_nx       = 1'b0;
        err_code_nx  = 1'b0;
        err_seq_nx   = 1'b0;
        err_stall_nx = 1'b0;
        if (s1_vld) begin
            if (!code_ok) begin
                err_code_nx = 1'b1;
                state_nx    = SYNC;
            end else begin
                case (state)
                    SYNC: begin
                        value_nx     = candidate;
                        upd_nx       = 1'b1;
                        stall_cnt_nx = '0;
                        state_nx     = TRACK;
                    end
                    TRACK: begin
                        if (candidate == value) begin
                            if (stall_inc > STALL_LIMIT) begin
                                err_stall_nx = 1'b1;
                                stall_cnt_nx = '0;
                            end else begin
                                stall_cnt_nx = stall_inc;
                            end
                        end else begin
                            err_seq_nx   = (candidate != successor);
                            value_nx     = candidate;
                            upd_nx       = 1'b1;
                            stall_cnt_nx = '0;
                        end
                    end
                    default: state_nx = SYNC;
                endcase
            end
        end
        err_cnt_nx = err_cnt;
        if ((err_code_nx || err_seq_nx || err_stall_nx) && (err_cnt != ERR_CNT_MAX)) begin
            err_cnt_nx = err_cnt + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= SYNC;
            stall_cnt <= '0;
            value     <= 10'd0;
            upd       <= 1'b0;
            err_code  <= 1'b0;
            err_seq   <= 1'b0;
            err_stall <= 1'b0;
            err_cnt   <= 8'd0;
        end else begin
            state     <= state_nx;
            stall_cnt <= stall_cnt_nx;
            value     <= value_nx;
            upd       <= upd_nx;
            err_code  <= err_code_nx;
            err_seq   <= err_seq_nx;
            err_stall <= err_stall_nx;
            err_cnt   <= err_cnt_nx;
        end
    end

endmodule

// File: tb/tb_seg7_rx_monitor.sv
// Scoreboard bench for seg7_rx_monitor: directed digit vectors queue their
// hand-computed responses, a monitor pops one whenever the DUT pulses.
module tb_seg7_rx_monitor;

    typedef struct packed {
        logic [9:0] value;
        logic       vld;
        logic       upd;
        logic       code;
        logic       seq;
        logic       stall;
        logic [7:0] cnt;
    } exp_t;

    localparam logic [7:0] BLANK = 8'h00;

    logic       clk;
    logic       rst;
    logic [7:0] seg0;
    logic [7:0] seg1;
    logic [7:0] seg2;
    logic [9:0] value;
    logic       value_vld;
    logic       upd;
    logic       err_code;
    logic       err_seq;
    logic       err_stall;
    logic [7:0] err_cnt;

    exp_t       exp_q[$];
    string      tag_q[$];
    int         checks = 0;
    int         errors = 0;
    bit         done   = 1'b0;
    logic [7:0] pat [10] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66,
                             8'h6D, 8'h7D, 8'h07, 8'h7F, 8'h6F};

    seg7_rx_monitor #(.STALL_MAX(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .seg0      (seg0),
        .seg1      (seg1),
        .seg2      (seg2),
        .value     (value),
        .value_vld (value_vld),
        .upd       (upd),
        .err_code  (err_code),
        .err_seq   (err_seq),
        .err_stall (err_stall),
        .err_cnt   (err_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic exp_t mk(int v, bit vld, bit u, bit c, bit q, bit s, int n);
        exp_t e;
        e.value = 10'(v);
        e.vld   = vld;
        e.upd   = u;
        e.code  = c;
        e.seq   = q;
        e.stall = s;
        e.cnt   = 8'(n);
        return e;
    endfunction

    function automatic string fmt(exp_t e);
        return $sformatf("value=%0d vld=%0b upd=%0b code=%0b seq=%0b stall=%0b cnt=%0d",
                         e.value, e.vld, e.upd, e.code, e.seq, e.stall, e.cnt);
    endfunction

    // Drives one display frame now (a falling edge) and holds it one cycle.
    task automatic apply_stimulus(input logic [7:0] s2, input logic [7:0] s1,
                                  input logic [7:0] s0, input bit has_exp,
                                  input exp_t e, input string tag);
        seg2 = s2;
        seg1 = s1;
        seg0 = s0;
        if (has_exp) begin
            exp_q.push_back(e);
            tag_q.push_back(tag);
        end
        @(negedge clk);
    endtask

    task automatic check_output(input exp_t act);
        exp_t  e;
        string tag;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("[TB] FAIL unexpected_event: got %s, required no pulse", fmt(act));
        end else begin
            e   = exp_q.pop_front();
            tag = tag_q.pop_front();
            if (act !== e) begin
                errors++;
                $display("[TB] FAIL %s: got %s, required %s", tag, fmt(act), fmt(e));
            end
        end
    endtask

    initial begin : monitor
        exp_t act;
        forever begin
            @(negedge clk or negedge rst);
            #1;
            act = {value, value_vld, upd, err_code, err_seq, err_stall, err_cnt};
            if (!rst) begin
                checks++;
                if (act !== '0) begin
                    errors++;
                    $display("[TB] FAIL reset_zero: got %s, required all zero", fmt(act));
                end
            end else if (upd || err_code || err_seq || err_stall) begin
                check_output(act);
            end
            if (done) begin
                checks++;
                if (exp_q.size() != 0) begin
                    errors++;
                    $display("[TB] FAIL queue_drain: got %0d pending events, required 0 (next %s)",
                             exp_q.size(), tag_q[0]);
                end
                $display("Result: errors=%0d of %0d checks", errors, checks);
                $finish;
            end
        end
    end

    initial begin : stimulus
        rst  = 1'b0;
        seg0 = 8'd0;
        seg1 = 8'd0;
        seg2 = 8'd0;
        repeat (3) @(negedge clk);
        rst = 1'b1;

        for (int n = 0; n <= 12; n++) begin
            apply_stimulus(pat[0], pat[n / 10], pat[n % 10], 1'b1,
                           mk(n, 1, 1, 0, 0, 0, 0), $sformatf("count_%0d", n));
        end
        apply_stimulus(pat[0], pat[1], pat[3], 1'b0, mk(0, 0, 0, 0, 0, 0, 0), "count_13_flushed");
        #2 rst = 1'b0;
        repeat (20) @(negedge clk);
        rst = 1'b1;

        apply_stimulus(BLANK, pat[4], pat[1] | 8'h80, 1'b1, mk(41, 1, 1, 0, 0, 0, 0), "post_reset_041_dp");
        apply_stimulus(BLANK, pat[4], pat[5], 1'b1, mk(45, 1, 1, 0, 1, 0, 1), "seq_jump_045");
        apply_stimulus(BLANK, pat[4], pat[6], 1'b1, mk(46, 1, 1, 0, 0, 0, 1), "inc_046");
        apply_stimulus(pat[9], pat[9], pat[8], 1'b1, mk(998, 1, 1, 0, 1, 0, 2), "resync_998");
        apply_stimulus(pat[9], pat[9], pat[9], 1'b1, mk(999, 1, 1, 0, 0, 0, 2), "inc_999");
        apply_stimulus(BLANK, BLANK, pat[0], 1'b1, mk(0, 1, 1, 0, 0, 0, 2), "wrap_000");
        apply_stimulus(BLANK, BLANK, pat[1], 1'b1, mk(1, 1, 1, 0, 0, 0, 2), "inc_001");
        apply_stimulus(BLANK, BLANK, 8'h49, 1'b1, mk(1, 0, 0, 1, 0, 0, 3), "bad_seg0_49");
        apply_stimulus(BLANK, BLANK, pat[5], 1'b1, mk(5, 1, 1, 0, 0, 0, 3), "sync_005");
        apply_stimulus(BLANK, BLANK, pat[6], 1'b1, mk(6, 1, 1, 0, 0, 0, 3), "inc_006");

        for (int k = 0; k < 8; k++) begin
            if (k == 0)
                apply_stimulus(BLANK, BLANK, pat[7], 1'b1, mk(7, 1, 1, 0, 0, 0, 3), "inc_007");
            else if (k == 3)
                apply_stimulus(BLANK, BLANK, pat[7], 1'b1, mk(7, 1, 0, 0, 0, 1, 4), "stall_first");
            else if (k == 6)
                apply_stimulus(BLANK, BLANK, pat[7], 1'b1, mk(7, 1, 0, 0, 0, 1, 5), "stall_second");
            else
                apply_stimulus(BLANK, BLANK, pat[7], 1'b0, mk(0, 0, 0, 0, 0, 0, 0), "hold_007");
        end

        apply_stimulus(pat[1], BLANK, pat[0], 1'b1, mk(7, 0, 0, 1, 0, 0, 6), "blank_tens_under_digit");
        apply_stimulus(BLANK, BLANK, BLANK, 1'b1, mk(7, 0, 0, 1, 0, 0, 7), "blank_ones");
        apply_stimulus(pat[1], pat[2], pat[3], 1'b1, mk(123, 1, 1, 0, 0, 0, 7), "sync_123");

        for (int k = 0; k < 250; k++) begin
            apply_stimulus(BLANK, BLANK, BLANK, 1'b1,
                           mk(123, 0, 0, 1, 0, 0, (8 + k > 255) ? 255 : 8 + k),
                           $sformatf("sat_%0d", k));
        end
        apply_stimulus(pat[1], pat[2], pat[4], 1'b1, mk(124, 1, 1, 0, 0, 0, 255), "sync_124_sat");

        repeat (2) @(negedge clk);
        done = 1'b1;
    end

    initial begin : watchdog
        #200000;
        $display("[TB] FAIL watchdog: got no end of run, required finish before time limit");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
